sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_pkg.sv | 28 ++
 rtl/sram_arbiter_rr_arbiter.sv | 39 +++
 rtl/sram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants, opcode type and width helpers for the SRAM bank arbiter.
package sram_pkg;

    localparam int STAT_W = 16;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int bank_w(input int num_banks);
        return (clog2(num_banks) < 1) ? 1 : clog2(num_banks);
    endfunction

    function automatic int port_id_w(input int num_ports);
        return (clog2(num_ports) < 1) ? 1 : clog2(num_ports);
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i (with wrap) wins.
module rr_arbiter
    import sram_pkg::*;
#(
    parameter int  NUM_PORTS = 4,
    localparam int PID_W     = port_id_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PID_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PID_W-1:0]     winner_o,
    output logic                 any_o
);

    logic [NUM_PORTS-1:0] req_rot;
    int                   win_idx;

    // Rotate so bit 0 is the port the pointer names; lowest set bit then wins.
    assign req_rot = NUM_PORTS'({req_i, req_i} >> ptr_i);

    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        any_o    = 1'b0;
        win_idx  = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                any_o   = 1'b1;
                win_idx = int'(ptr_i) + i;
            end
        end
        if (win_idx >= NUM_PORTS) win_idx = win_idx - NUM_PORTS;
        if (any_o) begin
            winner_o = PID_W'(win_idx);
            gnt_o    = NUM_PORTS'(1) << win_idx;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-port to multi-bank SRAM arbiter with per-bank round-robin and read return.
// Optional per-bank conflict counters are enabled by defining SRAM_ARB_STATS_EN.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int  NUM_PORTS  = 4,
    parameter int  NUM_BANKS  = 4,
    parameter int  ADDR_WIDTH = 12,
    parameter int  DATA_WIDTH = 32,
    localparam int BANK_W     = bank_w(NUM_BANKS),
    localparam int PID_W      = port_id_w(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*BANK_W-1:0]      req_bank,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata,
    output logic [NUM_BANKS-1:0]             bank_en,
    output logic [NUM_BANKS-1:0]             bank_we,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0]  bank_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_wdata,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_rdata,
    output logic                             err_oob
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [NUM_BANKS*STAT_W-1:0]      conflict_cnt
`endif
);

    logic [NUM_PORTS-1:0]           port_oob;
    logic [NUM_PORTS-1:0]           port_gnt;
    logic [NUM_BANKS*NUM_PORTS-1:0] gnt_flat;
    logic [NUM_BANKS-1:0]           rsp_bank_vld;
    logic [NUM_BANKS*PID_W-1:0]     rsp_bank_pid;
    logic                           err_oob_q, err_oob_d;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_oob[gi] = 32'(req_bank[gi*BANK_W +: BANK_W]) >= 32'(NUM_BANKS);
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [NUM_PORTS-1:0]  req_vec;
            logic [NUM_PORTS-1:0]  gnt;
            logic [PID_W-1:0]      winner;
            logic                  any_gnt;
            logic [PID_W-1:0]      rr_ptr_q, rr_ptr_d;
            logic                  en_q;
            op_e                   op_q, op_d;
            logic [ADDR_WIDTH-1:0] addr_q, addr_d;
            logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
            logic [PID_W-1:0]      pid_q;
            logic                  rsp_vld_q;
            logic [PID_W-1:0]      rsp_pid_q;

            always_comb begin
                req_vec = '0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    req_vec[p] = req_valid[p] && !port_oob[p] && !rst &&
                                 (req_bank[p*BANK_W +: BANK_W] == BANK_W'(gi));
                end
            end

            rr_arbiter #(
                .NUM_PORTS(NUM_PORTS)
            ) u_rr (
                .req_i    (req_vec),
                .ptr_i    (rr_ptr_q),
                .gnt_o    (gnt),
                .winner_o (winner),
                .any_o    (any_gnt)
            );

            always_comb begin
                op_d    = OP_READ;
                addr_d  = '0;
                wdata_d = '0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (gnt[p]) begin
                        op_d    = op_e'(req_we[p]);
                        addr_d  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_d = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                rr_ptr_d = rr_ptr_q;
                if (any_gnt) begin
                    rr_ptr_d = (winner == PID_W'(NUM_PORTS - 1)) ? '0 : winner + PID_W'(1);
                end
            end

            // Port ID travels with the command so the read return finds its requester.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_ptr_q  <= '0;
                    en_q      <= 1'b0;
                    op_q      <= OP_READ;
                    addr_q    <= '0;
                    wdata_q   <= '0;
                    pid_q     <= '0;
                    rsp_vld_q <= 1'b0;
                    rsp_pid_q <= '0;
                end else begin
                    rr_ptr_q  <= rr_ptr_d;
                    en_q      <= any_gnt;
                    op_q      <= op_d;
                    addr_q    <= addr_d;
                    wdata_q   <= wdata_d;
                    pid_q     <= winner;
                    rsp_vld_q <= en_q && (op_q == OP_READ);
                    rsp_pid_q <= pid_q;
                end
            end

            assign gnt_flat[gi*NUM_PORTS +: NUM_PORTS]     = gnt;
            assign bank_en[gi]                             = en_q;
            assign bank_we[gi]                             = en_q && (op_q == OP_WRITE);
            assign bank_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]  = addr_q;
            assign bank_wdata[gi*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
            assign rsp_bank_vld[gi]                        = rsp_vld_q;
            assign rsp_bank_pid[gi*PID_W +: PID_W]         = rsp_pid_q;

`ifdef SRAM_ARB_STATS_EN
            logic [STAT_W-1:0] conflict_q, conflict_d;

            always_comb begin
                conflict_d = conflict_q;
                if (((req_vec & (req_vec - NUM_PORTS'(1))) != '0) && (conflict_q != '1)) begin
                    conflict_d = conflict_q + STAT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) conflict_q <= '0;
                else     conflict_q <= conflict_d;
            end

            assign conflict_cnt[gi*STAT_W +: STAT_W] = conflict_q;
`endif
        end
    endgenerate

    always_comb begin
        port_gnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            port_gnt = port_gnt | gnt_flat[b*NUM_PORTS +: NUM_PORTS];
        end
    end

    // Out-of-range requests are accepted and discarded so the requester never stalls.
    assign req_ready = rst ? '0 : (req_valid & (port_oob | port_gnt));

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rsp_bank_vld[b] && (rsp_bank_pid[b*PID_W +: PID_W] == PID_W'(p))) begin
                    rsp_valid[p]                      = 1'b1;
                    rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign err_oob_d = err_oob_q || ((req_valid & port_oob & req_ready) != '0);

    always_ff @(posedge clk) begin
        if (rst) err_oob_q <= 1'b0;
        else     err_oob_q <= err_oob_d;
    end

    assign err_oob = err_oob_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_sram_arbiter;
    import sram_pkg::*;

    localparam int NP = 4;
    localparam int NB = 5;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int BW = bank_w(NB);
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NP*BW-1:0] req_bank;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata, rsp_rdata;
    logic [NB-1:0]    bank_en, bank_we;
    logic [NB*AW-1:0] bank_addr;
    logic [NB*DW-1:0] bank_wdata, bank_rdata;
    logic             err_oob;
`ifdef SRAM_ARB_STATS_EN
    logic [NB*16-1:0] conflict_cnt;
`endif

    sram_arbiter #(
        .NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .err_oob(err_oob)
`ifdef SRAM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    // Per-port stimulus
    logic          v  [NP];
    logic          w  [NP];
    int            bk [NP];
    int            ad [NP];
    logic [DW-1:0] wd [NP];

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            req_valid[p]            = v[p];
            req_we[p]               = w[p];
            req_bank[p*BW +: BW]    = BW'(bk[p]);
            req_addr[p*AW +: AW]    = AW'(ad[p]);
            req_wdata[p*DW +: DW]   = wd[p];
        end
    end

    function automatic logic [DW-1:0] init_word(input int b, input int a);
        return DW'(32'h5A00_0000 + b * 1000 + a * 7);
    endfunction

    // SRAM banks: registered read, data one cycle after bank_en
    logic [DW-1:0] mem  [NB][DEPTH];
    logic [DW-1:0] rd_q [NB];
    bit            mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < DEPTH; a++)
                    mem[b][a] <= init_word(b, a);
            mem_init <= 1'b1;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_en[b]) begin
                    if (bank_we[b]) mem[b][bank_addr[b*AW +: AW]] <= bank_wdata[b*DW +: DW];
                    else            rd_q[b] <= mem[b][bank_addr[b*AW +: AW]];
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = rd_q[b];
    end

    // Behavioural reference model
    typedef struct {
        bit            en;
        bit            we;
        int            port;
        int            addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t          st1 [NB];   // commands visible on bank_* this cycle
    cmd_t          st2 [NB];   // reads returning this cycle
    int            ptr [NB];
    logic [DW-1:0] shadow [NB][DEPTH];
    bit            exp_oob;
    int            conf [NB];
    int            waitc [NP];

    int            checks = 0;
    int            errors = 0;
    logic [NP-1:0] seen_ready;
    logic [NB-1:0] seen_en;
    logic [NP-1:0] seen_rsp;
    logic          seen_oob;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit chk);
        int            win [NB];
        int            p, n;
        logic [NP-1:0] er, ev;
        logic [NB-1:0] een, ewe;
        cmd_t          cur [NB];
        bit            any_oob;
        @(negedge clk);
        for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            for (int i = 0; i < NP; i++) begin
                p = (ptr[b] + i) % NP;
                if (win[b] < 0 && v[p] && bk[p] == b) win[b] = p;
            end
        end
        er = '0;
        for (int q = 0; q < NP; q++) begin
            if (!rst && v[q]) begin
                if (bk[q] >= NB) er[q] = 1'b1;
                else if (win[bk[q]] == q) er[q] = 1'b1;
            end
        end
        seen_ready = req_ready;
        seen_en    = bank_en;
        seen_rsp   = rsp_valid;
        seen_oob   = err_oob;
        if (chk) begin
            check("req_ready", req_ready, er);
            een = '0; ewe = '0; ev = '0;
            for (int b = 0; b < NB; b++) begin
                een[b] = st1[b].en;
                ewe[b] = st1[b].en && st1[b].we;
            end
            check("bank_en", bank_en, een);
            check("bank_we", bank_we, ewe);
            for (int b = 0; b < NB; b++) begin
                if (st1[b].en) check("bank_addr", bank_addr[b*AW +: AW], st1[b].addr);
                if (st1[b].en && st1[b].we) check("bank_wdata", bank_wdata[b*DW +: DW], st1[b].wdata);
                if (st2[b].en) ev[st2[b].port] = 1'b1;
            end
            check("rsp_valid", rsp_valid, ev);
            for (int b = 0; b < NB; b++) begin
                if (st2[b].en) check("rsp_rdata", rsp_rdata[st2[b].port*DW +: DW], st2[b].data);
            end
            check("err_oob", err_oob, exp_oob);
`ifdef SRAM_ARB_STATS_EN
            for (int b = 0; b < NB; b++) check("conflict_cnt", conflict_cnt[b*16 +: 16], conf[b]);
`endif
            for (int q = 0; q < NP; q++) begin
                if (rst) waitc[q] = 0;
                else if (v[q] && req_ready[q]) begin
                    check("wait_bound", waitc[q] <= NP - 1, 1'b1);
                    waitc[q] = 0;
                end else if (v[q]) waitc[q]++;
            end
        end
        // advance the model across the coming edge
        any_oob = 1'b0;
        for (int b = 0; b < NB; b++) begin
            cur[b] = '{en: 1'b0, we: 1'b0, port: 0, addr: 0, wdata: '0, data: '0};
            n = 0;
            for (int q = 0; q < NP; q++) if (v[q] && bk[q] == b) n++;
            if (rst) conf[b] = 0;
            else if (n > 1 && conf[b] < 65535) conf[b]++;
            if (!rst && win[b] >= 0) begin
                p = win[b];
                cur[b].en    = 1'b1;
                cur[b].we    = w[p];
                cur[b].port  = p;
                cur[b].addr  = ad[p];
                cur[b].wdata = wd[p];
                cur[b].data  = shadow[b][ad[p]];
                if (w[p]) shadow[b][ad[p]] = wd[p];
                ptr[b] = (p + 1) % NP;
            end
        end
        for (int q = 0; q < NP; q++) if (!rst && v[q] && bk[q] >= NB) any_oob = 1'b1;
        if (rst) begin
            exp_oob = 1'b0;
            for (int b = 0; b < NB; b++) begin
                ptr[b] = 0;
                st1[b].en = 1'b0;
                st2[b].en = 1'b0;
            end
        end else begin
            exp_oob = exp_oob | any_oob;
            for (int b = 0; b < NB; b++) begin
                st2[b]    = st1[b];
                st2[b].en = st1[b].en && !st1[b].we;
                st1[b]    = cur[b];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input bit we, input int bank, input int addr, input logic [DW-1:0] data);
        v[p] = 1'b1; w[p] = we; bk[p] = bank; ad[p] = addr; wd[p] = data;
    endtask

    task automatic clear_all();
        for (int p = 0; p < NP; p++) begin
            v[p] = 1'b0; w[p] = 1'b0; bk[p] = 0; ad[p] = 0; wd[p] = '0;
        end
    endtask

    initial begin
        logic [NP-1:0] order [5];
        int            r;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < DEPTH; a++) shadow[b][a] = init_word(b, a);
            st1[b] = '{en: 1'b0, we: 1'b0, port: 0, addr: 0, wdata: '0, data: '0};
            st2[b] = st1[b];
            ptr[b] = 0; conf[b] = 0;
        end
        for (int p = 0; p < NP; p++) waitc[p] = 0;
        exp_oob = 1'b0;
        clear_all();

        // Reset held two cycles, a request presented meanwhile must not be accepted
        rst = 1'b1;
        step(1'b0);
        set_req(0, 1'b0, 0, 1, '0);
        #1;
        check("rst_outputs", {bank_en, bank_we, rsp_valid, err_oob, req_ready}, '0);
        check("rst_wide", {|bank_addr, |bank_wdata, |rsp_rdata}, '0);
        step(1'b1);
        clear_all();
        rst = 1'b0;

        // Two ports contend for bank 2
        set_req(0, 1'b0, 2, 3, '0);
        set_req(1, 1'b0, 2, 4, '0);
        step(1'b1);
        check("contend_c0", seen_ready, 4'b0001);
        v[0] = 1'b0;
        step(1'b1);
        check("contend_c1", seen_ready, 4'b0010);
        v[1] = 1'b0;
        step(1'b1);
        check("contend_rsp0", seen_rsp, 4'b0001);
        step(1'b1);
        check("contend_rsp1", seen_rsp, 4'b0010);
        step(1'b1);

        // Four ports to four distinct banks in parallel
        set_req(0, 1'b1, 0, 5, 32'hDEAD_0000);
        set_req(1, 1'b0, 1, 6, '0);
        set_req(2, 1'b1, 2, 3, 32'hBEEF_0002);
        set_req(3, 1'b0, 3, 7, '0);
        step(1'b1);
        check("parallel_ready", seen_ready, 4'b1111);
        clear_all();
        step(1'b1);
        check("parallel_en", seen_en, 5'b01111);
        step(1'b1);
        step(1'b1);

        // Fairness: everybody hammers bank 0 from a fresh pointer
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, 0, p + 8, '0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1);
            check("rr_order", seen_ready, order[k]);
        end
        clear_all();
        step(1'b1);
        step(1'b1);

        // Out-of-range bank index
        set_req(2, 1'b0, 5, 0, '0);
        step(1'b1);
        check("oob_ready", seen_ready, 4'b0100);
        clear_all();
        step(1'b1);
        check("oob_no_en", seen_en, '0);
        check("oob_flag", seen_oob, 1'b1);
        step(1'b1);
        step(1'b1);
        check("oob_sticky", seen_oob, 1'b1);

        // Reset one cycle after a read is accepted drops the response
        set_req(0, 1'b0, 1, 2, '0);
        step(1'b1);
        clear_all();
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        step(1'b1);
        check("rst_drop_rsp", seen_rsp, '0);
        step(1'b1);
        step(1'b1);

        // Random traffic; each request is held until it is accepted
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            step(1'b1);
            for (int p = 0; p < NP; p++) begin
                if (!v[p] || seen_ready[p]) begin
                    v[p]  = ($urandom_range(0, 3) != 0);
                    w[p]  = ($urandom_range(0, 2) == 0);
                    r     = $urandom_range(0, 19);
                    bk[p] = (r == 0) ? $urandom_range(NB, 7) :
                            (r < 10) ? $urandom_range(0, 1) : $urandom_range(0, NB - 1);
                    ad[p] = $urandom_range(0, 7);
                    wd[p] = $urandom;
                end
            end
        end
        rst = 1'b0;
        clear_all();
        step(1'b1);
        step(1'b1);
        step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
